// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC unit: BOOT/RUN/HOLD sequencing, redirects, exception vector, delay-slot flags.
// Optional fetch address-error check is enabled by defining FETCH_ADEL_CHECK_EN.
module fetch_pc_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redir_sel,
    input  logic [31:0] redir_target,
    input  logic        is_slot,
    input  logic        clear_slot,
    input  logic        exc_req,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        f_bd,
    output logic        f_kill,
    output logic        f_adel,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fsm_t;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;

    fsm_t        cur;
    logic [31:0] pend_target;

    // A redirect that arrives while F is frozen is parked in pend_target and
    // applied on the first unstalled edge; exceptions always win and drop it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur         <= BOOT;
            pc          <= RESET_PC;
            pend_target <= '0;
        end else begin
            case (cur)
                BOOT: cur <= RUN;
                RUN: begin
                    if (exc_req) begin
                        pc <= EXC_VEC;
                    end else if (redir_sel && !stall) begin
                        pc <= redir_target;
                    end else if (redir_sel) begin
                        pend_target <= redir_target;
                        cur         <= HOLD;
                    end else if (!stall) begin
                        pc <= pc4;
                    end
                end
                HOLD: begin
                    if (exc_req) begin
                        pc          <= EXC_VEC;
                        pend_target <= '0;
                        cur         <= RUN;
                    end else if (!stall) begin
                        pc  <= pend_target;
                        cur <= RUN;
                    end
                end
                default: cur <= BOOT;
            endcase
        end
    end

    assign pc4    = pc + 32'd4;
    assign state  = cur;
    assign f_kill = (cur == BOOT) | exc_req | (clear_slot & ~stall);
    assign f_bd   = is_slot & ~f_kill;

`ifdef FETCH_ADEL_CHECK_EN
    // Legal fetch window is word-aligned 0x3000..0x6FFC; a squashed fetch never faults.
    assign f_adel = ~f_kill & ((pc[1:0] != 2'b00) ||
                               (pc < 32'h0000_3000) ||
                               (pc > 32'h0000_6FFC));
`else
    assign f_adel = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed-vector bench for fetch_pc_unit with a queue scoreboard and a negedge monitor.
module tb_fetch_pc_unit;

`ifdef FETCH_ADEL_CHECK_EN
    localparam bit ADEL_ON = 1'b1;
`else
    localparam bit ADEL_ON = 1'b0;
`endif

    logic        clk = 1'b1;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redir_sel = 1'b0;
    logic [31:0] redir_target = '0;
    logic        is_slot = 1'b0;
    logic        clear_slot = 1'b0;
    logic        exc_req = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        f_bd;
    logic        f_kill;
    logic        f_adel;
    logic [1:0]  state;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        kill;
        logic        bd;
        logic        adel;
        logic [1:0]  st;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_push = 0;
    bit   done = 1'b0;

    fetch_pc_unit dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .redir_sel    (redir_sel),
        .redir_target (redir_target),
        .is_slot      (is_slot),
        .clear_slot   (clear_slot),
        .exc_req      (exc_req),
        .pc           (pc),
        .pc4          (pc4),
        .f_bd         (f_bd),
        .f_kill       (f_kill),
        .f_adel       (f_adel),
        .state        (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            if (pc !== e.pc || pc4 !== e.pc4 || f_kill !== e.kill || f_bd !== e.bd ||
                f_adel !== e.adel || state !== e.st) begin
                n_bad++;
                $display("FAIL %s: got pc=%h pc4=%h kill=%b bd=%b adel=%b st=%0d, want pc=%h pc4=%h kill=%b bd=%b adel=%b st=%0d",
                         e.name, pc, pc4, f_kill, f_bd, f_adel, state,
                         e.pc, e.pc4, e.kill, e.bd, e.adel, e.st);
            end
        end
    end

    initial begin
        #5000;
        if (!done) begin
            n_bad++;
            $display("FAIL timeout: stimulus did not complete within 5000 time units");
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    task automatic drive_and_push(input logic s, input logic rs, input logic [31:0] tg,
                                  input logic sl, input logic cl, input logic ex, input logic rt,
                                  input logic [31:0] epc, input logic ek, input logic eb,
                                  input logic ea, input logic [1:0] est, input string nm);
        exp_t e;
        stall        = s;
        redir_sel    = rs;
        redir_target = tg;
        is_slot      = sl;
        clear_slot   = cl;
        exc_req      = ex;
        reset        = rt;
        e.pc   = epc;
        e.pc4  = epc + 32'd4;
        e.kill = ek;
        e.bd   = eb;
        e.adel = ea & ADEL_ON;
        e.st   = est;
        e.name = nm;
        sb.push_back(e);
        n_push++;
    endtask

    // One cycle: inputs applied just after the edge, expected outputs for that cycle.
    task automatic step(input logic s, input logic rs, input logic [31:0] tg,
                        input logic sl, input logic cl, input logic ex, input logic rt,
                        input logic [31:0] epc, input logic ek, input logic eb,
                        input logic ea, input logic [1:0] est, input string nm);
        @(posedge clk);
        #1;
        drive_and_push(s, rs, tg, sl, cl, ex, rt, epc, ek, eb, ea, est, nm);
    endtask

    initial begin
        // Reset asserted between edges with is_slot high: outputs must settle without a clock.
        #1;
        drive_and_push(0, 0, 32'h0, 1, 0, 0, 1, 32'h3000, 1, 0, 0, 2'd0, "reset_async");
        #1;
        if (pc !== 32'h0000_3000 || state !== 2'd0 || f_kill !== 1'b1 ||
            f_bd !== 1'b0 || f_adel !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_immediate: got pc=%h st=%0d kill=%b bd=%b adel=%b before any clock edge",
                     pc, state, f_kill, f_bd, f_adel);
        end
        //   stall rsel target         slot clr exc rst  pc            kill bd adel st
        step(0, 0, 32'h0,         0, 0, 0, 0, 32'h0000_3000, 1, 0, 0, 2'd0, "boot");
        step(0, 0, 32'h0,         0, 0, 0, 0, 32'h0000_3000, 0, 0, 0, 2'd1, "run_first");
        step(0, 0, 32'h0,         0, 0, 0, 0, 32'h0000_3004, 0, 0, 0, 2'd1, "run_3004");
        step(0, 0, 32'h0,         0, 0, 0, 0, 32'h0000_3008, 0, 0, 0, 2'd1, "run_3008");
        step(0, 0, 32'h0,         0, 0, 0, 0, 32'h0000_300C, 0, 0, 0, 2'd1, "run_300c");
        step(0, 1, 32'h3100,      1, 0, 0, 0, 32'h0000_3010, 0, 1, 0, 2'd1, "delay_slot_bd");
        step(1, 1, 32'h3200,      0, 0, 0, 0, 32'h0000_3100, 0, 0, 0, 2'd1, "redir_taken");
        step(1, 1, 32'h9990,      0, 0, 0, 0, 32'h0000_3100, 0, 0, 0, 2'd2, "hold_1");
        step(0, 0, 32'h0,         0, 0, 0, 0, 32'h0000_3100, 0, 0, 0, 2'd2, "hold_2");
        step(0, 0, 32'h0,         1, 1, 0, 0, 32'h0000_3200, 1, 0, 0, 2'd1, "pend_applied");
        step(0, 1, 32'h3044,      1, 1, 0, 0, 32'h0000_3204, 1, 0, 0, 2'd1, "eret_squash");
        step(1, 0, 32'h0,         1, 1, 0, 0, 32'h0000_3044, 0, 1, 0, 2'd1, "clr_stalled");
        step(0, 0, 32'h0,         0, 0, 0, 0, 32'h0000_3044, 0, 0, 0, 2'd1, "stall_held");
        step(1, 1, 32'h5000,      0, 0, 0, 0, 32'h0000_3048, 0, 0, 0, 2'd1, "redir_stall_2");
        step(1, 0, 32'h0,         1, 0, 1, 0, 32'h0000_3048, 1, 0, 0, 2'd2, "exc_in_hold");
        step(1, 0, 32'h0,         0, 0, 0, 0, 32'h0000_4180, 0, 0, 0, 2'd1, "exc_vector");
        step(0, 0, 32'h0,         0, 0, 0, 0, 32'h0000_4180, 0, 0, 0, 2'd1, "pend_dropped");
        step(0, 1, 32'h6000,      0, 0, 1, 0, 32'h0000_4184, 1, 0, 0, 2'd1, "exc_over_redir");
        step(0, 1, 32'h3002,      0, 0, 0, 0, 32'h0000_4180, 0, 0, 0, 2'd1, "exc_vector_2");
        step(0, 1, 32'h7000,      0, 0, 0, 0, 32'h0000_3002, 0, 0, 1, 2'd1, "adel_unaligned");
        step(0, 1, 32'h6FFC,      0, 0, 0, 0, 32'h0000_7000, 0, 0, 1, 2'd1, "adel_above");
        step(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'h0000_6FFC, 0, 0, 0, 2'd1, "adel_top_ok");
        step(0, 1, 32'h2FFC,      0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 1, 2'd1, "pc4_wrap");
        step(0, 0, 32'h0,         0, 0, 1, 0, 32'h0000_2FFC, 1, 0, 0, 2'd1, "adel_killed");
        step(1, 1, 32'h3300,      0, 0, 0, 0, 32'h0000_4180, 0, 0, 0, 2'd1, "redir_stall_3");
        step(1, 0, 32'h0,         0, 0, 0, 0, 32'h0000_4180, 0, 0, 0, 2'd2, "hold_3");
        step(1, 0, 32'h0,         0, 0, 0, 1, 32'h0000_3000, 1, 0, 0, 2'd0, "reset_mid_hold");
        step(0, 0, 32'h0,         0, 0, 0, 0, 32'h0000_3000, 1, 0, 0, 2'd0, "boot_again");
        step(0, 0, 32'h0,         0, 0, 0, 0, 32'h0000_3000, 0, 0, 0, 2'd1, "first_fetch");
        step(0, 0, 32'h0,         0, 0, 0, 0, 32'h0000_3004, 0, 0, 0, 2'd1, "after_reset");
        @(negedge clk);
        #1;
        done = 1'b1;
        if (sb.size() != 0 || n_cmp != n_push) begin
            n_bad++;
            $display("FAIL scoreboard: %0d queued, %0d compared, %0d left", n_push, n_cmp, sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
